mat_add_2x2: RTL and testbench

//   Sequential 2x2 signed matrix adder: C = A + B, element-wise.
//   One shared adder processes the four elements in row-major order.

---
 rtl/mat_add_2x2.sv | 96 +++++++++
 tb/tb_mat_add_2x2.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mat_add_2x2.sv
// Sequential 2x2 signed matrix adder C = A + B using one shared adder, row-major.
// Build option: define MATADD_SAT_EN to saturate each sum instead of wrapping.
module mat_add_2x2 #(
  parameter int BIT_PREC = 8
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               start,
  input  logic [1:0][1:0][BIT_PREC-1:0]      A,
  input  logic [1:0][1:0][BIT_PREC-1:0]      B,
  output logic [1:0][1:0][BIT_PREC-1:0]      C,
  output logic                               valid,
  output logic                               busy,
  output logic [1:0]                         state_dbg
);

  // Handshake: start is sampled only in IDLE (ignored otherwise, never queued);
  // valid pulses for one cycle when C carries a new result; busy = state != IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Flattened row-major operand copies: element i = (i[1], i[0]).
  logic [3:0][BIT_PREC-1:0] aq, bq, sq;
  logic [1:0]               idx;
  logic [BIT_PREC-1:0]      res;

`ifdef MATADD_SAT_EN
  logic [BIT_PREC:0] wide;
  always_comb begin
    wide = {aq[idx][BIT_PREC-1], aq[idx]} + {bq[idx][BIT_PREC-1], bq[idx]};
    res  = wide[BIT_PREC-1:0];
    // Sign bits disagree only on overflow; clamp toward the true sign.
    if (wide[BIT_PREC] != wide[BIT_PREC-1])
      res = wide[BIT_PREC] ? {1'b1, {(BIT_PREC-1){1'b0}}} : {1'b0, {(BIT_PREC-1){1'b1}}};
  end
`else
  always_comb begin
    res = aq[idx] + bq[idx];
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ADD;
      ADD:     if (idx == 2'd3) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aq    <= '0;
      bq    <= '0;
      sq    <= '0;
      idx   <= '0;
      C     <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            aq  <= A;
            bq  <= B;
            idx <= 2'd0;
          end
        end
        ADD: begin
          sq[idx] <= res;
          idx     <= idx + 2'd1;
          if (idx == 2'd3) begin
            C     <= {res, sq[2], sq[1], sq[0]};
            valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mat_add_2x2.sv
// Directed bench for mat_add_2x2: reset, basic, signed, overflow, operand capture, reset mid-op.
module tb_mat_add_2x2;

  logic                     clk;
  logic                     rstn;
  logic                     start;
  logic [1:0][1:0][7:0]     A, B, C;
  logic                     valid, busy;
  logic [1:0]               state_dbg;

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  logic [31:0] exp_q[$];

  mat_add_2x2 #(.BIT_PREC(8)) dut (
    .clk(clk), .rstn(rstn), .start(start), .A(A), .B(B),
    .C(C), .valid(valid), .busy(busy), .state_dbg(state_dbg)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rstn && valid) vcount++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mat(input int e00, input int e01, input int e10, input int e11);
    logic [7:0] a, b, c, d;
    a = e00[7:0]; b = e01[7:0]; c = e10[7:0]; d = e11[7:0];
    return {d, c, b, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: issue one request, check latency, busy width, valid width and C
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int cyc;
    int busy_cnt;
    logic [31:0] e;
    exp_q.push_back(exp);
    A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    busy_cnt = busy ? 1 : 0;
    while (!valid && cyc < 12) begin
      tick();
      cyc++;
      if (busy) busy_cnt++;
    end
    check({tag, "_latency"}, cyc, 4);
    e = exp_q.pop_front();
    check({tag, "_c"}, C, e);
    tick();
    check({tag, "_valid_1cyc"}, valid, 1'b0);
    check({tag, "_busy_cnt"}, busy_cnt, 5);
    check({tag, "_idle"}, {state_dbg, busy}, {2'd0, 1'b0});
  endtask

  initial begin
    int vc0;
    rstn = 1'b0; start = 1'b0; A = '0; B = '0;
    tick(); tick();
    check("rst_c", C, 32'h0);
    check("rst_flags", {valid, busy, state_dbg}, 4'b0);
    rstn = 1'b1;
    tick(); tick(); tick();
    check("post_rst_c", C, 32'h0);
    check("post_rst_flags", {valid, busy, state_dbg}, 4'b0);

    run_op("basic", mat(1, 2, 3, 4), mat(1, 2, 3, 4), mat(2, 4, 6, 8));
    tick(); tick();
    check("c_hold", C, mat(2, 4, 6, 8));

    run_op("signed", mat(-5, 7, 0, -128), mat(3, -7, -1, 0), mat(-2, 0, -1, -128));
`ifdef MATADD_SAT_EN
    run_op("ovf", mat(100, -100, 127, -128), mat(100, -100, 1, -1), mat(127, -128, 127, -128));
`else
    run_op("ovf", mat(100, -100, 127, -128), mat(100, -100, 1, -1), mat(-56, 56, -128, 127));
`endif

    // operand capture and ignored start while busy
    vc0 = vcount;
    A = mat(1, 2, 3, 4); B = mat(10, 20, 30, 40); start = 1'b1;
    tick();
    start = 1'b0;
    A = mat(50, 50, 50, 50); B = mat(-1, -1, -1, -1);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("cap_c", C, mat(11, 22, 33, 44));
    check("cap_one_valid", vcount - vc0, 1);
    check("cap_idle", {busy, state_dbg}, 3'b0);

    // reset mid-operation
    vc0 = vcount;
    A = mat(9, 9, 9, 9); B = mat(1, 1, 1, 1); start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rstn = 1'b0;
    #1;
    check("midrst_c", C, 32'h0);
    check("midrst_flags", {valid, busy, state_dbg}, 4'b0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("midrst_no_valid", vcount - vc0, 0);
    check("midrst_c_hold", C, 32'h0);
    run_op("after_rst", mat(-5, 7, 0, -128), mat(3, -7, -1, 0), mat(-2, 0, -1, -128));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
